// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier, one multiplier bit per clock, with valid/ready on both sides.
// Optional SEQ_MULT_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module seq_mult_hs #(
  parameter int XLEN = 16,
  localparam int CNTW = $clog2(XLEN + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              signed_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] product_o,
  output logic              busy
);

  localparam logic [XLEN-1:0]   X_ONE = XLEN'(1);
  localparam logic [2*XLEN-1:0] P_ONE = (2 * XLEN)'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic                ready_en;
  logic                signed_q;
  logic                sign_x;
  logic [XLEN-1:0]     mplier;
  logic [2*XLEN-1:0]   mcand;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   prod_q;
  logic [CNTW-1:0]     cnt;

  logic [XLEN-1:0]     a_mag, b_mag, mplier_sh;
  logic [2*XLEN-1:0]   acc_sum, result;
  logic [CNTW-1:0]     cnt_dec;
  logic                last, neg, accept;

  assign a_mag     = (signed_i && a_i[XLEN-1]) ? (~a_i + X_ONE) : a_i;
  assign b_mag     = (signed_i && b_i[XLEN-1]) ? (~b_i + X_ONE) : b_i;
  assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
  assign mplier_sh = mplier >> 1;
  assign cnt_dec   = cnt - CNTW'(1);
  assign neg       = signed_q & sign_x;
  assign result    = neg ? (~acc_sum + P_ONE) : acc_sum;
  assign accept    = (state == IDLE) && in_valid && ready_en;
  assign product_o = prod_q;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last = (cnt_dec == '0) || (mplier_sh == '0);
`else
  assign last = (cnt_dec == '0);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ready_en;
        if (in_valid && ready_en) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ready_en holds in_ready low for the whole reset and releases it one edge later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_en <= 1'b0;
      signed_q <= 1'b0;
      sign_x   <= 1'b0;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      prod_q   <= '0;
      cnt      <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            signed_q <= signed_i;
            sign_x   <= a_i[XLEN-1] ^ b_i[XLEN-1];
            mcand    <= {{XLEN{1'b0}}, a_mag};
            mplier   <= b_mag;
            acc      <= '0;
            cnt      <= CNTW'(XLEN);
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt_dec;
          if (last) prod_q <= result;
        end
        DONE: begin
          if (out_ready) prod_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
